mips_regfile: RTL and testbench
===============================

Name: mips_regfile

Overview:
- 32-entry general-purpose register file for the 32-bit MIPS datapath.
- Sits directly upstream of the ALU: its two read ports drive the ALU operand buses a/b, which feed the bitwise units (and32, or32, ...) and the adder.
- Writeback from the ALU/memory stage returns through the single write port.
- Register $0 reads as zero.

Parameters:
- DATA_W, 32, register and data width in bits.
- ADDR_W, 5, register address width; depth = 2**ADDR_W = 32.
- BYPASS, 1, 1 = read-during-write returns the write data (write-through); 0 = returns the old contents.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous active-high reset.
- rs_addr  input  ADDR_W  read port A address (instr[25:21]).
- rt_addr  input  ADDR_W  read port B address (instr[20:16]).
- rs_data  output  DATA_W  read port A data; ALU operand a.
- rt_data  output  DATA_W  read port B data; ALU operand b / store data.
- wr_en  input  1  write enable (RegWrite).
- wr_addr  input  ADDR_W  write address (rd or rt, selected by RegDst upstream).
- wr_data  input  DATA_W  write data (ALU result or load data).

Behaviour:
- Reset: rst=1 asynchronously clears all 32 registers to 0 while rst is high.
  - rs_data and rt_data are therefore 0 during reset.
  - A write presented while rst=1 is discarded.
  - rst deasserting mid-cycle does not cause a write until the next rising edge with rst=0.
- Write: on posedge clk with rst=0 and wr_en=1 and wr_addr!=0, reg[wr_addr] <= wr_data.
  - Writes to address 0 are ignored; reg[0] is constant 0 (no storage flops).
- Read: combinational, zero-cycle latency from address to data.
  - Address 0 always returns 0, regardless of wr_en or BYPASS.
- Bypass (BYPASS=1): if wr_en=1, wr_addr!=0 and wr_addr==rs_addr, then rs_data=wr_data in the same cycle. rt_data follows the same rule independently. Both ports may bypass simultaneously.
- BYPASS=0: a read of the address being written returns the old value until after the edge.
- Simultaneous read of the same address on both ports is legal; both ports return identical data.
- Write data is stored unmodified, with no sign or width manipulation.
- No X on outputs after reset for any address combination.
- No handshake and no stall: the write is accepted every cycle wr_en=1.

Decomposition:
- Shared package constants: REG_ZERO=0, REG_SP=29, REG_RA=31, DATA_W=32, ADDR_W=5.
  - These are also used by the control unit and the jal writeback mux.
- One sub-module: decoder5to32 (5-bit address to 32 one-hot write strobes, gated by wr_en).
  - Built in the same gate-level style as the existing 32-bit bitwise units; reused by future CP0 registers.
- Read muxes and bypass compare stay inline.

Test Plan:
- Reset clear: preload reg5=0xDEADBEEF, assert rst asynchronously between edges -> rs_addr=5 reads 0x00000000 immediately, before the next edge.
- Basic write/read: write reg8=0x12345678 and reg9=0x0F0F0F0F, then rs=8, rt=9 -> rs_data=0x12345678, rt_data=0x0F0F0F0F; downstream and32 yields 0x02040608.
- Zero register: wr_en=1, wr_addr=0, wr_data=0xFFFFFFFF; next cycle rs=0, rt=0 -> both 0x00000000, including in the write cycle with BYPASS=1.
- Bypass: reg3=0x1, same cycle wr_en=1, wr_addr=3, wr_data=0xAAAA5555, rs=rt=3 -> both ports 0xAAAA5555 (BYPASS=1) or 0x00000001 (BYPASS=0); after the edge both give 0xAAAA5555.
- Write during reset: rst=1 with wr_en=1, wr_addr=31, wr_data=0xCAFEF00D across an edge; release rst -> reg31 reads 0x00000000.
- Sweep: write reg[i]=i*0x01010101 for i=1..31, read every pair (i, 31-i) -> exact values; reg0=0.

Source files
------------

// File: rtl/mips_regfile_pkg.sv
// Shared MIPS register-file constants, also used by the control unit and the jal writeback mux.
package mips_regfile_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [ADDR_W-1:0] REG_SP   = 5'd29;
  localparam logic [ADDR_W-1:0] REG_RA   = 5'd31;
endpackage

// File: rtl/mips_regfile_if.sv
// Register-file read/write bus: two combinational read ports and one write port.
interface mips_regfile_if #(
  parameter int DATA_W = mips_regfile_pkg::DATA_W,
  parameter int ADDR_W = mips_regfile_pkg::ADDR_W
);
  import mips_regfile_pkg::*;

  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    output rs_addr, rt_addr, wr_en, wr_addr, wr_data,
    input  rs_data, rt_data
  );

  modport slave (
    input  rs_addr, rt_addr, wr_en, wr_addr, wr_data,
    output rs_data, rt_data
  );
endinterface

// File: rtl/mips_regfile_decoder5to32.sv
// 5-bit address to 32 one-hot strobes gated by enable; plain AND/XNOR gate form.
module decoder5to32
  import mips_regfile_pkg::*;
(
  input  logic [4:0]  i_addr,
  input  logic        i_en,
  output logic [31:0] o_sel
);
  for (genvar gi = 0; gi < 32; gi++) begin : g_line
    localparam logic [4:0] C_MATCH = gi[4:0];
    assign o_sel[gi] = i_en & (&(~(i_addr ^ C_MATCH)));
  end
endmodule

// File: rtl/mips_regfile.sv
// 32-entry MIPS GPR file: async-clear storage, combinational reads, optional write-through bypass.
module mips_regfile #(
  parameter int DATA_W = mips_regfile_pkg::DATA_W,
  parameter int ADDR_W = mips_regfile_pkg::ADDR_W,
  parameter bit BYPASS = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  mips_regfile_if.slave  bus
);
  import mips_regfile_pkg::*;

  localparam int DEPTH = 1 << ADDR_W;

  // Entry 0 has no storage; it is tied to zero in the read view.
  logic [DATA_W-1:0] r_regs [1:DEPTH-1];
  logic [DATA_W-1:0] w_file [DEPTH];
  logic [DEPTH-1:0]  w_wr_sel;
  logic              w_byp_rs;
  logic              w_byp_rt;

  decoder5to32 u_dec (
    .i_addr (bus.wr_addr),
    .i_en   (bus.wr_en),
    .o_sel  (w_wr_sel)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < DEPTH; i++) r_regs[i] <= '0;
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        if (w_wr_sel[i]) r_regs[i] <= bus.wr_data;
      end
    end
  end

  assign w_file[0] = '0;
  for (genvar gi = 1; gi < DEPTH; gi++) begin : g_file
    assign w_file[gi] = r_regs[gi];
  end

  // Bypass is held off during reset so both ports read zero while rst is high.
  assign w_byp_rs = BYPASS && !rst && (bus.rs_addr != REG_ZERO) && w_wr_sel[bus.rs_addr];
  assign w_byp_rt = BYPASS && !rst && (bus.rt_addr != REG_ZERO) && w_wr_sel[bus.rt_addr];

  assign bus.rs_data = w_byp_rs ? bus.wr_data : w_file[bus.rs_addr];
  assign bus.rt_data = w_byp_rt ? bus.wr_data : w_file[bus.rt_addr];
endmodule

// File: tb/tb_mips_regfile.sv
// Drives identical traffic into a write-through and a non-bypass register file and checks both against an array model.
module tb_mips_regfile;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  rs_addr = '0;
  logic [4:0]  rt_addr = '0;
  logic        wr_en   = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;

  int checks = 0;
  int errors = 0;
  logic [31:0] model [32];

  mips_regfile_if bus_b1 ();
  mips_regfile_if bus_b0 ();

  assign bus_b1.rs_addr = rs_addr;
  assign bus_b1.rt_addr = rt_addr;
  assign bus_b1.wr_en   = wr_en;
  assign bus_b1.wr_addr = wr_addr;
  assign bus_b1.wr_data = wr_data;
  assign bus_b0.rs_addr = rs_addr;
  assign bus_b0.rt_addr = rt_addr;
  assign bus_b0.wr_en   = wr_en;
  assign bus_b0.wr_addr = wr_addr;
  assign bus_b0.wr_data = wr_data;

  mips_regfile #(.BYPASS(1'b1)) u_dut_b1 (.clk(clk), .rst(rst), .bus(bus_b1));
  mips_regfile #(.BYPASS(1'b0)) u_dut_b0 (.clk(clk), .rst(rst), .bus(bus_b0));

  always #5 clk = ~clk;

  // What a read port must show right now, from the architectural rules.
  function automatic logic [31:0] expect_rd(input logic [4:0] a, input bit byp);
    if (rst || a == 5'd0) return 32'h0;
    if (byp && wr_en && wr_addr == a) return wr_data;
    return model[a];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reads(input string tag);
    #1;
    check({tag, " b1.rs"}, bus_b1.rs_data, expect_rd(rs_addr, 1'b1));
    check({tag, " b1.rt"}, bus_b1.rt_data, expect_rd(rt_addr, 1'b1));
    check({tag, " b0.rs"}, bus_b0.rs_data, expect_rd(rs_addr, 1'b0));
    check({tag, " b0.rt"}, bus_b0.rt_data, expect_rd(rt_addr, 1'b0));
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst && wr_en && wr_addr != 5'd0) model[wr_addr] = wr_data;
    #1;
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd);
    rs_addr = rs; rt_addr = rt; wr_en = we; wr_addr = wa; wr_data = wd;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'h0;

    rst = 1'b1;
    tick();
    check_reads("reset_state");
    rst = 1'b0;
    #2;

    // Asynchronous clear between edges
    drive(5, 5, 1'b1, 5, 32'hDEADBEEF);
    tick();
    drive(5, 5, 1'b0, 0, 32'h0);
    check_reads("preload_r5");
    check("preload_r5 value", bus_b1.rs_data, 32'hDEADBEEF);
    rst = 1'b1;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    check_reads("async_clear");
    check("async_clear r5", bus_b0.rs_data, 32'h0);
    tick();
    rst = 1'b0;
    #2;

    drive(0, 0, 1'b1, 8, 32'h12345678);
    tick();
    drive(0, 0, 1'b1, 9, 32'h0F0F0F0F);
    tick();
    drive(8, 9, 1'b0, 0, 32'h0);
    check_reads("basic_rw");
    check("and32 of operands", bus_b1.rs_data & bus_b1.rt_data, 32'h02040608);

    drive(0, 0, 1'b1, 0, 32'hFFFFFFFF);
    check_reads("zero_write_cycle");
    tick();
    drive(0, 0, 1'b0, 0, 32'h0);
    check_reads("zero_after");

    drive(0, 0, 1'b1, 3, 32'h00000001);
    tick();
    drive(3, 3, 1'b1, 3, 32'hAAAA5555);
    check_reads("bypass_cycle");
    check("bypass b1", bus_b1.rs_data, 32'hAAAA5555);
    check("no_bypass b0", bus_b0.rt_data, 32'h00000001);
    tick();
    drive(3, 3, 1'b0, 0, 32'h0);
    check_reads("bypass_after");

    // Write held across an edge during reset must be dropped
    rst = 1'b1;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    drive(31, 31, 1'b1, 31, 32'hCAFEF00D);
    check_reads("write_in_reset");
    tick();
    #2;
    rst = 1'b0;
    drive(31, 31, 1'b0, 0, 32'h0);
    check_reads("after_reset_write");
    check("r31 dropped", bus_b0.rs_data, 32'h0);
    tick();

    for (int i = 1; i < 32; i++) begin
      drive(0, 0, 1'b1, 5'(i), 32'(i) * 32'h01010101);
      tick();
    end
    drive(0, 0, 1'b0, 0, 32'h0);
    for (int i = 0; i < 32; i++) begin
      drive(5'(i), 5'(31 - i), 1'b0, 0, 32'h0);
      check_reads($sformatf("sweep_%0d", i));
    end

    for (int n = 0; n < 300; n++) begin
      drive(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom);
      if (n % 7 == 0) rt_addr = rs_addr;
      if (n % 11 == 0) rs_addr = wr_addr;
      check_reads($sformatf("rand_%0d", n));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
